// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared FSM state type, LFSR mask and default grid geometry
// Purpose: common types and constants for the food spawner slice.
// Contents: state_t (IDLE/PICK/CHECK/PLACE), LFSR_MASK, DEF_* grid defaults.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    CHECK = 2'd2,
    PLACE = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam int DEF_MIN_X  = 16;
  localparam int DEF_MIN_Y  = 16;
  localparam int DEF_STEP_X = 32;
  localparam int DEF_STEP_Y = 32;
  localparam int DEF_COLS   = 43;
  localparam int DEF_ROWS   = 23;

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR random source
// Purpose: advances once per clock out of reset; SEED must be nonzero.
// Ports: clk, btnrst_n (sync active-low reset), state[15:0] (current LFSR value).
module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        btnrst_n,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (!btnrst_n) begin
      state <= SEED;
    end else if (state[0]) begin
      state <= (state >> 1) ^ LFSR_MASK;
    end else begin
      state <= state >> 1;
    end
  end

endmodule

// File: rtl/food_spawner.sv
// rtl/food_spawner.sv - apple placement FSM with random pick, collision check and raster fallback
// Purpose: keeps NUM_APPLES apples on free grid cells and detects the snake eating them.
// Ports: clk, btnrst_n (sync active-low reset), enable (eat detection on),
//        snakehead_x/y (head pixel position), wall_x/y (flattened wall cells),
//        apple_x/y (flattened apple positions), apple_valid (slot occupied),
//        eaten_pulse (one cycle per eat), eat_count (saturating eat total).
module food_spawner
  import snake_pkg::*;
#(
  parameter int          COORD_W    = 11,
  parameter int          NUM_APPLES = 2,
  parameter int          NUM_WALLS  = 4,
  parameter int          MIN_X      = DEF_MIN_X,
  parameter int          MIN_Y      = DEF_MIN_Y,
  parameter int          STEP_X     = DEF_STEP_X,
  parameter int          STEP_Y     = DEF_STEP_Y,
  parameter int          COLS       = DEF_COLS,
  parameter int          ROWS       = DEF_ROWS,
  parameter int          MAX_TRIES  = 8,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            btnrst_n,
  input  logic                            enable,
  input  logic [COORD_W-1:0]              snakehead_x,
  input  logic [COORD_W-1:0]              snakehead_y,
  input  logic [NUM_WALLS*COORD_W-1:0]    wall_x,
  input  logic [NUM_WALLS*COORD_W-1:0]    wall_y,
  output logic [NUM_APPLES*COORD_W-1:0]   apple_x,
  output logic [NUM_APPLES*COORD_W-1:0]   apple_y,
  output logic [NUM_APPLES-1:0]           apple_valid,
  output logic                            eaten_pulse,
  output logic [15:0]                     eat_count
);

  localparam int AIDX_W = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;

  state_t              state, state_nxt;
  logic [15:0]         lfsr;
  logic [AIDX_W-1:0]   target, first_empty;
  logic                any_empty;
  logic [7:0]          cand_col, cand_row;
  logic [7:0]          scan_col, scan_row, scan_col_nxt, scan_row_nxt;
  logic [7:0]          last_col, last_row;
  logic                last_ok, raster;
  logic [7:0]          try_cnt;
  logic [COORD_W-1:0]  cand_x, cand_y;
  logic                in_range, collide, reject;
  logic [NUM_APPLES-1:0] hit;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .btnrst_n (btnrst_n),
    .state    (lfsr)
  );

  always_comb begin
    cand_x = COORD_W'(MIN_X) + COORD_W'(cand_col) * COORD_W'(STEP_X);
    cand_y = COORD_W'(MIN_Y) + COORD_W'(cand_row) * COORD_W'(STEP_Y);
    in_range = ({1'b0, cand_col} < 9'(COLS)) && ({1'b0, cand_row} < 9'(ROWS));

    collide = (cand_x == snakehead_x) && (cand_y == snakehead_y);
    for (int i = 0; i < NUM_WALLS; i++) begin
      if (cand_x == wall_x[i*COORD_W +: COORD_W] && cand_y == wall_y[i*COORD_W +: COORD_W])
        collide = 1'b1;
    end
    // The target slot is invalid, so it never collides with itself.
    for (int i = 0; i < NUM_APPLES; i++) begin
      if (apple_valid[i] && cand_x == apple_x[i*COORD_W +: COORD_W] &&
          cand_y == apple_y[i*COORD_W +: COORD_W])
        collide = 1'b1;
    end
    reject = !in_range || collide;

    hit = '0;
    for (int i = 0; i < NUM_APPLES; i++) begin
      hit[i] = enable && apple_valid[i] &&
               (apple_x[i*COORD_W +: COORD_W] == snakehead_x) &&
               (apple_y[i*COORD_W +: COORD_W] == snakehead_y);
    end

    // Descending loop so the lowest empty index wins.
    first_empty = '0;
    any_empty   = 1'b0;
    for (int i = NUM_APPLES - 1; i >= 0; i--) begin
      if (!apple_valid[i]) begin
        first_empty = AIDX_W'(i);
        any_empty   = 1'b1;
      end
    end

    // Row-major raster successor with wrap to (0,0).
    scan_row_nxt = scan_row;
    if ({1'b0, scan_col} >= 9'(COLS - 1)) begin
      scan_col_nxt = 8'd0;
      scan_row_nxt = ({1'b0, scan_row} >= 9'(ROWS - 1)) ? 8'd0 : scan_row + 8'd1;
    end else begin
      scan_col_nxt = scan_col + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_empty) state_nxt = PICK;
      PICK:    state_nxt = CHECK;
      CHECK:   state_nxt = reject ? PICK : PLACE;
      PLACE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!btnrst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!btnrst_n) begin
      apple_x     <= '0;
      apple_y     <= '0;
      apple_valid <= '0;
      eaten_pulse <= 1'b0;
      eat_count   <= 16'd0;
      target      <= '0;
      cand_col    <= 8'd0;
      cand_row    <= 8'd0;
      scan_col    <= 8'd0;
      scan_row    <= 8'd0;
      last_col    <= 8'd0;
      last_row    <= 8'd0;
      last_ok     <= 1'b0;
      raster      <= 1'b0;
      try_cnt     <= 8'd0;
    end else begin
      eaten_pulse <= |hit;
      if (|hit && eat_count != 16'hFFFF) eat_count <= eat_count + 16'd1;
      // Eat clears first; a PLACE below on the same slot overrides it.
      apple_valid <= apple_valid & ~hit;

      case (state)
        IDLE: if (any_empty) target <= first_empty;
        PICK: begin
          if (raster) begin
            cand_col <= scan_col;
            cand_row <= scan_row;
            scan_col <= scan_col_nxt;
            scan_row <= scan_row_nxt;
          end else begin
            cand_col <= lfsr[7:0];
            cand_row <= lfsr[15:8];
          end
        end
        CHECK: begin
          if (in_range) begin
            last_col <= cand_col;
            last_row <= cand_row;
            last_ok  <= 1'b1;
          end
          if (reject && !raster) begin
            try_cnt <= try_cnt + 8'd1;
            if (({1'b0, try_cnt} + 9'd1) >= 9'(MAX_TRIES)) begin
              raster <= 1'b1;
              if (in_range) begin
                scan_col <= cand_col;
                scan_row <= cand_row;
              end else if (last_ok) begin
                scan_col <= last_col;
                scan_row <= last_row;
              end else begin
                scan_col <= 8'd0;
                scan_row <= 8'd0;
              end
            end
          end
        end
        PLACE: begin
          for (int i = 0; i < NUM_APPLES; i++) begin
            if (AIDX_W'(i) == target) begin
              apple_x[i*COORD_W +: COORD_W] <= cand_x;
              apple_y[i*COORD_W +: COORD_W] <= cand_y;
              apple_valid[i]                <= 1'b1;
            end
          end
          try_cnt <= 8'd0;
          raster  <= 1'b0;
          last_ok <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// tb/tb_food_spawner.sv - directed self-checking bench for food_spawner
module tb_food_spawner;
  import snake_pkg::*;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, enable_a, enable_b;
  logic [10:0] head_x_a, head_y_a, head_x_b, head_y_b;
  logic [43:0] wall_x_a, wall_y_a;
  logic [21:0] apple_x_a, apple_y_a;
  logic [1:0]  apple_valid_a;
  logic        eaten_pulse_a, eaten_pulse_b;
  logic [15:0] eat_count_a, eat_count_b;
  logic [10:0] apple_x_b, apple_y_b;
  logic [0:0]  apple_valid_b;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt_a = 0;

  // Walls: (16,16) (48,16) (80,16) (16,48)
  assign wall_x_a = {11'd16, 11'd80, 11'd48, 11'd16};
  assign wall_y_a = {11'd48, 11'd16, 11'd16, 11'd16};

  food_spawner dut_a (
    .clk(clk), .btnrst_n(rst_a), .enable(enable_a),
    .snakehead_x(head_x_a), .snakehead_y(head_y_a),
    .wall_x(wall_x_a), .wall_y(wall_y_a),
    .apple_x(apple_x_a), .apple_y(apple_y_a), .apple_valid(apple_valid_a),
    .eaten_pulse(eaten_pulse_a), .eat_count(eat_count_a)
  );

  food_spawner #(.NUM_APPLES(1), .NUM_WALLS(1), .COLS(2), .ROWS(1)) dut_b (
    .clk(clk), .btnrst_n(rst_b), .enable(enable_b),
    .snakehead_x(head_x_b), .snakehead_y(head_y_b),
    .wall_x(11'd16), .wall_y(11'd16),
    .apple_x(apple_x_b), .apple_y(apple_y_b), .apple_valid(apple_valid_b),
    .eaten_pulse(eaten_pulse_b), .eat_count(eat_count_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (eaten_pulse_a) pulse_cnt_a = pulse_cnt_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // On the default 43x23 grid and not on one of the four walls.
  function automatic logic free_cell(input logic [10:0] x, input logic [10:0] y);
    int dx, dy;
    dx = int'(x) - 16;
    dy = int'(y) - 16;
    if (dx < 0 || dy < 0 || dx % 32 != 0 || dy % 32 != 0) return 1'b0;
    if (dx / 32 >= 43 || dy / 32 >= 23) return 1'b0;
    if ((x == 16 && y == 16) || (x == 48 && y == 16) || (x == 80 && y == 16) || (x == 16 && y == 48))
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_fill_a(input logic [1:0] want, input int budget, input string tag);
    for (int i = 0; i < budget && apple_valid_a != want; i++) @(negedge clk);
    chk(tag, apple_valid_a, want);
  endtask

  task automatic wait_fill_b(input int budget, input string tag);
    for (int i = 0; i < budget && apple_valid_b != 1'b1; i++) @(negedge clk);
    chk(tag, apple_valid_b, 1);
  endtask

  logic [15:0] lfsr_exp;
  logic [10:0] hx, hy, a1x, a1y;
  int p0;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
    head_x_a = 11'd112; head_y_a = 11'd112;
    head_x_b = 11'd500; head_y_b = 11'd500;
    repeat (3) @(negedge clk);

    chk("rst_valid", apple_valid_a, 0);
    chk("rst_apple_x", apple_x_a, 0);
    chk("rst_apple_y", apple_y_a, 0);
    chk("rst_count", eat_count_a, 0);
    chk("rst_pulse", eaten_pulse_a, 0);
    chk("rst_lfsr", dut_a.lfsr, 16'hACE1);

    rst_a = 1'b1; rst_b = 1'b1;
    lfsr_exp = 16'hACE1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lfsr_exp = lfsr_step(lfsr_exp);
    end
    chk("lfsr_seq", dut_a.lfsr, lfsr_exp);

    // Initial fill of both slots
    wait_fill_a(2'b11, 2000, "fill_a");
    chk("distinct", (apple_x_a[10:0] != apple_x_a[21:11]) || (apple_y_a[10:0] != apple_y_a[21:11]), 1);
    chk("grid_a0", free_cell(apple_x_a[10:0], apple_y_a[10:0]), 1);
    chk("grid_a1", free_cell(apple_x_a[21:11], apple_y_a[21:11]), 1);
    chk("not_head_a0", (apple_x_a[10:0] != head_x_a) || (apple_y_a[10:0] != head_y_a), 1);

    // Eat apple 0
    hx = apple_x_a[10:0]; hy = apple_y_a[10:0];
    a1x = apple_x_a[21:11]; a1y = apple_y_a[21:11];
    p0 = pulse_cnt_a;
    head_x_a = hx; head_y_a = hy; enable_a = 1'b1;
    @(negedge clk);
    chk("eat_valid0", apple_valid_a[0], 0);
    chk("eat_pulse", eaten_pulse_a, 1);
    chk("eat_count1", eat_count_a, 1);
    wait_fill_a(2'b11, 2000, "refill_a");
    chk("one_pulse", pulse_cnt_a - p0, 1);
    chk("new0_not_head", (apple_x_a[10:0] != hx) || (apple_y_a[10:0] != hy), 1);
    chk("new0_not_a1", (apple_x_a[10:0] != a1x) || (apple_y_a[10:0] != a1y), 1);
    chk("new0_grid", free_cell(apple_x_a[10:0], apple_y_a[10:0]), 1);
    chk("a1_held", {apple_x_a[21:11], apple_y_a[21:11]}, {a1x, a1y});

    // Head on apple 1 with eat detection off
    enable_a = 1'b0;
    head_x_a = a1x; head_y_a = a1y;
    p0 = pulse_cnt_a;
    repeat (6) @(negedge clk);
    chk("dis_valid", apple_valid_a, 2'b11);
    chk("dis_count", eat_count_a, 1);
    chk("dis_pulses", pulse_cnt_a - p0, 0);

    // Saturation of eat_count
    force dut_a.eat_count = 16'hFFFF;
    @(negedge clk);
    release dut_a.eat_count;
    head_x_a = apple_x_a[10:0]; head_y_a = apple_y_a[10:0]; enable_a = 1'b1;
    @(negedge clk);
    chk("sat_count", eat_count_a, 16'hFFFF);
    chk("sat_pulse", eaten_pulse_a, 1);
    chk("sat_valid0", apple_valid_a[0], 0);

    // Reset while the refill is in CHECK
    for (int i = 0; i < 50 && dut_a.state != CHECK; i++) @(negedge clk);
    chk("reach_check", dut_a.state == CHECK, 1);
    rst_a = 1'b0;
    @(negedge clk);
    chk("rchk_valid", apple_valid_a, 0);
    chk("rchk_x", apple_x_a, 0);
    chk("rchk_y", apple_y_a, 0);
    chk("rchk_pulse", eaten_pulse_a, 0);
    chk("rchk_count", eat_count_a, 0);
    rst_a = 1'b1;

    // Tiny grid: the only free cell is (48,16)
    wait_fill_b(200, "fill_b");
    chk("b_x", apple_x_b, 48);
    chk("b_y", apple_y_b, 16);
    for (int k = 0; k < 3; k++) begin
      head_x_b = 11'd48; head_y_b = 11'd16; enable_b = 1'b1;
      @(negedge clk);
      chk("b_eat_valid", apple_valid_b, 0);
      chk("b_eat_count", eat_count_b, k + 1);
      repeat (150) @(negedge clk);
      chk("b_nofree_valid", apple_valid_b, 0);
      head_x_b = 11'd500; head_y_b = 11'd500;
      wait_fill_b(200, "b_refill");
      chk("b_re_x", apple_x_b, 48);
      chk("b_re_y", apple_y_b, 16);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
